multi_data_counter: RTL and testbench

//  Multi-channel up/down value counter for front-panel data entry.
//  Per-channel value with selectable output code, programmable step, saturation at range limits and

---
 rtl/dcnt_pkg.sv | 32 +++
 rtl/multi_data_counter_if.sv | 24 ++
 rtl/dcnt_repeat.sv | 89 ++++++++
 rtl/multi_data_counter.sv | 119 +++++++++++
 tb/tb_multi_data_counter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dcnt_pkg.sv
// Shared types and range/encoding helpers for the multi-channel data counter.
// Helpers work on int and assume WIDTH stays well below 31 bits.
package dcnt_pkg;

    typedef enum logic [1:0] {UNSIGNED, SIGN_MAG, ONES_COMP, TWOS_COMP} code_e;

    typedef enum logic [1:0] {IDLE, FIRST, REPEAT} rep_state_e;

    function automatic int range_max(code_e code, int w);
        return (code == UNSIGNED) ? (1 << w) - 1 : (1 << (w - 1)) - 1;
    endfunction

    function automatic int range_min(code_e code, int w);
        case (code)
            UNSIGNED:  return 0;
            TWOS_COMP: return -(1 << (w - 1));
            default:   return -((1 << (w - 1)) - 1);
        endcase
    endfunction

    // Caller keeps the low w bits of the result.
    function automatic logic [31:0] encode(code_e code, int w, int val);
        int mag;
        mag = (val < 0) ? -val : val;
        case (code)
            SIGN_MAG:  return (val < 0) ? ((32'd1 << (w - 1)) | 32'(mag)) : 32'(val);
            ONES_COMP: return (val < 0) ? 32'(val - 1) : 32'(val);
            default:   return 32'(val);
        endcase
    endfunction

endpackage

// File: rtl/multi_data_counter_if.sv
// Front-panel bus of the data counter: controls in (master drives), encoded values and flags out.
interface multi_data_counter_if #(
    parameter int WIDTH    = 5,
    parameter int CHANNELS = 4,
    parameter int STEP_W   = 3
);
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [SEL_W-1:0]                sel;
    logic                            up;
    logic                            down;
    logic                            sign_sw;
    logic                            clear;
    logic [STEP_W-1:0]               step;
    logic [CHANNELS-1:0][WIDTH-1:0]  data;
    logic                            at_max;
    logic                            at_min;
    logic                            evt;

    modport master (output sel, up, down, sign_sw, clear, step,
                    input  data, at_max, at_min, evt);
    modport slave  (input  sel, up, down, sign_sw, clear, step,
                    output data, at_max, at_min, evt);
endinterface

// File: rtl/dcnt_repeat.sv
// Up/Down edge detection and auto-repeat FSM; events are issued combinationally in the
// cycle the press (or repeat tick) is seen so the value updates with 1-cycle latency.
module dcnt_repeat
    import dcnt_pkg::*;
#(
    parameter int REPEAT_DELAY  = 4,
    parameter int REPEAT_PERIOD = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic up_i,
    input  logic down_i,
    input  logic cancel_i,
    output logic inc_evt_o,
    output logic dec_evt_o
);
    localparam int MAXC  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W = $clog2(MAXC + 1);

    rep_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dir_up_q;
    logic             up_q, down_q;
    logic             armed_q;
    logic             up_rise, dn_rise, held, fire;

    // A button still held through reset must be released before it counts as a press.
    assign up_rise = up_i & ~up_q & ~down_i & armed_q;
    assign dn_rise = down_i & ~down_q & ~up_i & armed_q;
    assign held    = dir_up_q ? (up_i & ~down_i) : (down_i & ~up_i);

    always_comb begin
        fire = 1'b0;
        case (state_q)
            IDLE:    fire = ~cancel_i & (up_rise | dn_rise);
            FIRST:   fire = ~cancel_i & held & (cnt_q == CNT_W'(REPEAT_DELAY - 1));
            REPEAT:  fire = ~cancel_i & held & (cnt_q == CNT_W'(REPEAT_PERIOD - 1));
            default: fire = 1'b0;
        endcase
    end

    assign inc_evt_o = fire & ((state_q == IDLE) ? up_rise : dir_up_q);
    assign dec_evt_o = fire & ((state_q == IDLE) ? dn_rise : ~dir_up_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dir_up_q <= 1'b0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            up_q    <= up_i;
            down_q  <= down_i;
            armed_q <= armed_q | (~up_i & ~down_i);
            case (state_q)
                IDLE: begin
                    if (fire) begin
                        state_q  <= FIRST;
                        cnt_q    <= '0;
                        dir_up_q <= up_rise;
                    end
                end
                FIRST: begin
                    if (cancel_i || !held) begin
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_W'(REPEAT_DELAY - 1)) begin
                        state_q <= REPEAT;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                REPEAT: begin
                    if (cancel_i || !held) begin
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_W'(REPEAT_PERIOD - 1)) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/multi_data_counter.sv
// Multi-channel up/down value counter with selectable output code and auto-repeat.
// Define MULTI_DATA_COUNTER_WRAP_EN to wrap out-of-range results instead of saturating.
module multi_data_counter
    import dcnt_pkg::*;
#(
    parameter int    WIDTH         = 5,
    parameter int    CHANNELS      = 4,
    parameter code_e CODE          = UNSIGNED,
    parameter int    STEP_W        = 3,
    parameter int    REPEAT_DELAY  = 4,
    parameter int    REPEAT_PERIOD = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    multi_data_counter_if.slave  bus
);
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int VW    = WIDTH + 1;
    localparam int VMAX  = range_max(CODE, WIDTH);
    localparam int VMIN  = range_min(CODE, WIDTH);

    logic signed [VW-1:0]           val_q [CHANNELS];
    logic signed [VW-1:0]           val_d [CHANNELS];
    logic [CHANNELS-1:0][WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0]               sel_q;
    logic                           sw_q;
    logic                           evt_q, evt_d;
    logic                           at_max_q, at_max_d;
    logic                           at_min_q, at_min_d;
    logic                           inc_evt, dec_evt, cancel, sw_rise;
    int                             cur, nxt;

    function automatic int limit(int v);
`ifdef MULTI_DATA_COUNTER_WRAP_EN
        int span, r;
        span = VMAX - VMIN + 1;
        r    = (v - VMIN) % span;
        if (r < 0) r = r + span;
        return r + VMIN;
`else
        if (v > VMAX) return VMAX;
        if (v < VMIN) return VMIN;
        return v;
`endif
    endfunction

    assign cancel  = (bus.sel != sel_q) | bus.clear;
    assign sw_rise = bus.sign_sw & ~sw_q;

    dcnt_repeat #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_repeat (
        .clk       (clk),
        .rst       (rst),
        .up_i      (bus.up),
        .down_i    (bus.down),
        .cancel_i  (cancel),
        .inc_evt_o (inc_evt),
        .dec_evt_o (dec_evt)
    );

    always_comb begin
        val_d    = val_q;
        evt_d    = 1'b0;
        at_max_d = 1'b0;
        at_min_d = 1'b0;
        cur      = 0;
        nxt      = 0;
        if (int'(bus.sel) < CHANNELS) begin
            cur = int'(val_q[bus.sel]);
            nxt = cur;
            if (bus.clear) begin
                nxt = 0;
            end else if (sw_rise) begin
                // Two's-complement MIN has no positive counterpart, so it is left alone.
                if (CODE != UNSIGNED && !(CODE == TWOS_COMP && cur == VMIN)) nxt = -cur;
            end else if (inc_evt) begin
                nxt   = limit(cur + int'(bus.step));
                evt_d = 1'b1;
            end else if (dec_evt) begin
                nxt   = limit(cur - int'(bus.step));
                evt_d = 1'b1;
            end
            val_d[bus.sel] = VW'(nxt);
            at_max_d       = (nxt == VMAX);
            at_min_d       = (nxt == VMIN);
        end
        for (int c = 0; c < CHANNELS; c++) begin
            data_d[c] = WIDTH'(encode(CODE, WIDTH, int'(val_d[c])));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q    <= '{default: '0};
            data_q   <= '0;
            sel_q    <= '0;
            sw_q     <= 1'b0;
            evt_q    <= 1'b0;
            at_max_q <= 1'b0;
            at_min_q <= (VMIN == 0);
        end else begin
            val_q    <= val_d;
            data_q   <= data_d;
            sel_q    <= bus.sel;
            sw_q     <= bus.sign_sw;
            evt_q    <= evt_d;
            at_max_q <= at_max_d;
            at_min_q <= at_min_d;
        end
    end

    assign bus.data   = data_q;
    assign bus.evt    = evt_q;
    assign bus.at_max = at_max_q;
    assign bus.at_min = at_min_q;

endmodule

// File: tb/tb_multi_data_counter.sv
// Bench: one counter per output code, driven by directed steps; expectations are queued
// as stimulus is applied and compared just after the following clock edge.
module tb_multi_data_counter;
    import dcnt_pkg::*;

    localparam int W = 5, CH = 4, SW = 3;
    localparam int S_DATA = 0, S_EVT = 1, S_MAX = 2, S_MIN = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multi_data_counter_if #(.WIDTH(W), .CHANNELS(CH), .STEP_W(SW)) if_u (), if_t (), if_s (), if_o ();

    multi_data_counter #(.WIDTH(W), .CHANNELS(CH), .CODE(UNSIGNED), .STEP_W(SW),
        .REPEAT_DELAY(4), .REPEAT_PERIOD(2)) dut_u (.clk(clk), .rst(rst), .bus(if_u.slave));
    multi_data_counter #(.WIDTH(W), .CHANNELS(CH), .CODE(TWOS_COMP), .STEP_W(SW),
        .REPEAT_DELAY(4), .REPEAT_PERIOD(2)) dut_t (.clk(clk), .rst(rst), .bus(if_t.slave));
    multi_data_counter #(.WIDTH(W), .CHANNELS(CH), .CODE(SIGN_MAG), .STEP_W(SW),
        .REPEAT_DELAY(4), .REPEAT_PERIOD(2)) dut_s (.clk(clk), .rst(rst), .bus(if_s.slave));
    multi_data_counter #(.WIDTH(W), .CHANNELS(CH), .CODE(ONES_COMP), .STEP_W(SW),
        .REPEAT_DELAY(4), .REPEAT_PERIOD(2)) dut_o (.clk(clk), .rst(rst), .bus(if_o.slave));

    typedef struct {
        string       tag;
        int          d;
        int          sig;
        int          ch;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic push(string tag, int d, int sig, int ch, logic [31:0] exp);
        exp_t e;
        e.tag = tag; e.d = d; e.sig = sig; e.ch = ch; e.exp = exp;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] obs(int d, int sig, int ch);
        logic [CH-1:0][W-1:0] dv;
        logic ev, mx, mn;
        case (d)
            0:       begin dv = if_u.data; ev = if_u.evt; mx = if_u.at_max; mn = if_u.at_min; end
            1:       begin dv = if_t.data; ev = if_t.evt; mx = if_t.at_max; mn = if_t.at_min; end
            2:       begin dv = if_s.data; ev = if_s.evt; mx = if_s.at_max; mn = if_s.at_min; end
            default: begin dv = if_o.data; ev = if_o.evt; mx = if_o.at_max; mn = if_o.at_min; end
        endcase
        case (sig)
            S_DATA:  return 32'(dv[ch]);
            S_EVT:   return {31'b0, ev};
            S_MAX:   return {31'b0, mx};
            default: return {31'b0, mn};
        endcase
    endfunction

    task automatic check_all();
        exp_t        e;
        logic [31:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.d, e.sig, e.ch);
            n_assert++;
            assert (o === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_in(int d, logic [1:0] sel, logic up, logic dn, logic sw, logic clr, logic [2:0] step);
        case (d)
            0: begin if_u.sel = sel; if_u.up = up; if_u.down = dn; if_u.sign_sw = sw; if_u.clear = clr; if_u.step = step; end
            1: begin if_t.sel = sel; if_t.up = up; if_t.down = dn; if_t.sign_sw = sw; if_t.clear = clr; if_t.step = step; end
            2: begin if_s.sel = sel; if_s.up = up; if_s.down = dn; if_s.sign_sw = sw; if_s.clear = clr; if_s.step = step; end
            default: begin if_o.sel = sel; if_o.up = up; if_o.down = dn; if_o.sign_sw = sw; if_o.clear = clr; if_o.step = step; end
        endcase
    endtask

    // One-cycle press then release; queued expectations are checked after the press edge.
    task automatic pulse(int d, logic up, logic dn, logic [2:0] step);
        set_in(d, 2'd0, up, dn, 1'b0, 1'b0, step);
        tick();
        set_in(d, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, step);
        tick();
    endtask

    int   cnt;
    logic ev;

    initial begin
        for (int d = 0; d < 4; d++) set_in(d, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        rst = 1'b1;
        #2;
        for (int c = 0; c < CH; c++) push("rst_data_u", 0, S_DATA, c, 0);
        push("rst_evt_u", 0, S_EVT, 0, 0);
        push("rst_atmin_u", 0, S_MIN, 0, 1);
        push("rst_atmax_u", 0, S_MAX, 0, 0);
        push("rst_atmin_t", 1, S_MIN, 0, 0);
        push("rst_data_s", 2, S_DATA, 0, 0);
        check_all();
        #10 rst = 1'b0;
        tick(); tick();

        // 1. UNSIGNED auto-repeat from 0 with Up held for 12 cycles.
        set_in(0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            ev = (k == 0 || k == 4 || k == 6 || k == 8 || k == 10);
            if (ev) cnt++;
            push("t1_evt", 0, S_EVT, 0, {31'b0, ev});
            push("t1_d0", 0, S_DATA, 0, cnt);
            tick();
        end
        push("t1_final_d0", 0, S_DATA, 0, 5);
        for (int c = 1; c < CH; c++) push("t1_other", 0, S_DATA, c, 0);
        check_all();
        set_in(0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        tick();

        // 2. TWOS_COMP: build up to 15, then Up at the top of the range.
        push("t2_d7", 1, S_DATA, 0, 7);
        pulse(1, 1'b1, 1'b0, 3'd7);
        push("t2_d14", 1, S_DATA, 0, 14);
        pulse(1, 1'b1, 1'b0, 3'd7);
        push("t2_d15", 1, S_DATA, 0, 5'b01111);
        push("t2_atmax15", 1, S_MAX, 0, 1);
        pulse(1, 1'b1, 1'b0, 3'd1);
        push("t2_top_evt", 1, S_EVT, 0, 1);
`ifdef MULTI_DATA_COUNTER_WRAP_EN
        push("t2_top_data", 1, S_DATA, 0, 5'b10000);
        push("t2_top_atmin", 1, S_MIN, 0, 1);
        push("t2_top_atmax", 1, S_MAX, 0, 0);
`else
        push("t2_top_data", 1, S_DATA, 0, 5'b01111);
        push("t2_top_atmax", 1, S_MAX, 0, 1);
`endif
        pulse(1, 1'b1, 1'b0, 3'd1);

        // 3. SIGN_MAG: Down from 0, negate, clear, negate zero.
        push("t3_down", 2, S_DATA, 0, 5'b10001);
        pulse(2, 1'b0, 1'b1, 3'd1);
        set_in(2, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1);
        push("t3_neg", 2, S_DATA, 0, 5'b00001);
        push("t3_neg_evt", 2, S_EVT, 0, 0);
        tick();
        set_in(2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1);
        push("t3_clear", 2, S_DATA, 0, 0);
        tick();
        set_in(2, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1);
        push("t3_neg_zero", 2, S_DATA, 0, 5'b00000);
        tick();
        set_in(2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        tick();

        // 4. ONES_COMP: +1 then repeated Down by 3 into the lower limit.
        push("t4_p1", 3, S_DATA, 0, 5'b00001);
        pulse(3, 1'b1, 1'b0, 3'd1);
        push("t4_m2", 3, S_DATA, 0, 5'b11101);
        pulse(3, 1'b0, 1'b1, 3'd3);
        push("t4_m5", 3, S_DATA, 0, 5'b11010);
        pulse(3, 1'b0, 1'b1, 3'd3);
        push("t4_m8", 3, S_DATA, 0, 5'b10111);
        pulse(3, 1'b0, 1'b1, 3'd3);
        push("t4_m11", 3, S_DATA, 0, 5'b10100);
        pulse(3, 1'b0, 1'b1, 3'd3);
        push("t4_m14", 3, S_DATA, 0, 5'b10001);
        pulse(3, 1'b0, 1'b1, 3'd3);
        push("t4_lim_evt", 3, S_EVT, 0, 1);
`ifdef MULTI_DATA_COUNTER_WRAP_EN
        push("t4_lim_data", 3, S_DATA, 0, 5'b01110);
        push("t4_lim_atmin", 3, S_MIN, 0, 0);
`else
        push("t4_lim_data", 3, S_DATA, 0, 5'b10000);
        push("t4_lim_atmin", 3, S_MIN, 0, 1);
`endif
        pulse(3, 1'b0, 1'b1, 3'd3);

        // 5. Sel change mid-hold cancels; Up&Down together never steps.
        set_in(0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
        push("t5_first_evt", 0, S_EVT, 0, 1);
        push("t5_d0", 0, S_DATA, 0, 6);
        push("t5_atmin0", 0, S_MIN, 0, 0);
        tick();
        push("t5_hold1", 0, S_EVT, 0, 0);
        tick();
        push("t5_hold2", 0, S_EVT, 0, 0);
        tick();
        set_in(0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
        push("t5_selchg_evt", 0, S_EVT, 0, 0);
        push("t5_selchg_atmin", 0, S_MIN, 0, 1);
        push("t5_selchg_d0", 0, S_DATA, 0, 6);
        tick();
        for (int k = 0; k < 6; k++) begin
            push("t5_held_evt", 0, S_EVT, 0, 0);
            push("t5_held_d1", 0, S_DATA, 1, 0);
            tick();
        end
        set_in(0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        tick();
        set_in(0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
        push("t5_repress_evt", 0, S_EVT, 0, 1);
        push("t5_repress_d1", 0, S_DATA, 1, 1);
        tick();
        set_in(0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        tick();
        set_in(0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1);
        push("t5_both_evt", 0, S_EVT, 0, 0);
        tick();
        push("t5_both_evt2", 0, S_EVT, 0, 0);
        push("t5_both_d1", 0, S_DATA, 1, 1);
        tick();
        set_in(0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        tick();

        // 6. Asynchronous reset while repeating; held Up must not fire afterwards.
        set_in(0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
        for (int k = 0; k < 8; k++) tick();
        #3 rst = 1'b1;
        #1;
        push("t6_rst_d0", 0, S_DATA, 0, 0);
        push("t6_rst_d1", 0, S_DATA, 1, 0);
        push("t6_rst_evt", 0, S_EVT, 0, 0);
        push("t6_rst_atmin", 0, S_MIN, 0, 1);
        push("t6_rst_t_d0", 1, S_DATA, 0, 0);
        check_all();
        #2 rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            push("t6_held_evt", 0, S_EVT, 0, 0);
            push("t6_held_d0", 0, S_DATA, 0, 0);
            tick();
        end
        set_in(0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        tick();
        set_in(0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
        push("t6_repress_evt", 0, S_EVT, 0, 1);
        push("t6_repress_d0", 0, S_DATA, 0, 1);
        tick();
        set_in(0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
